// File: rtl/impulse_pkg.sv
// Shared types and constants for the impulse arbiter.
package impulse_pkg;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_REL   = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  // Channel identifiers as carried on grant.
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // The channel that is not ch (two-way round-robin step).
  function automatic logic other_ch(input logic ch);
    return ~ch;
  endfunction

endpackage

// File: rtl/impulse_rr_pick.sv
// Two-way round-robin pick: a lone valid request wins; on a tie the
// channel that was not served last wins.
module impulse_rr_pick
  import impulse_pkg::*;
(
  input  logic vA,
  input  logic vB,
  input  logic last,
  output logic valid,
  output logic win
);

  // Combinational winner selection.
  always_comb begin
    valid = vA | vB;
    win   = CH_A;
    if (vA && vB) begin
      win = other_ch(last);
    end else if (vB) begin
      win = CH_B;
    end
  end

endmodule

// File: rtl/impulse_arbiter.sv
// Impulse arbiter: shares one pulse line between producers A and B.
//
// Handshake: dav_x is active-low "data valid" from the producer, rfd_x is
// active-high "ready for data" from this block. A transfer happens at the
// edge where dav_x=0 and rfd_x=1 are both sampled; the served producer then
// sees rfd_x fall and must keep dav_x low (data stable) until it chooses to
// release. rfd_x rises again at the edge that samples dav_x=1 in REL.
// The losing channel keeps rfd=1, since a falling rfd means "accepted".
//
// Sequence: IDLE -> PULSE (out high for data[LEN_W-1:0]+1 cycles)
//           -> REL (wait for release) -> GAP (GAP idle cycles) -> IDLE.
module impulse_arbiter
  import impulse_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int GAP    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              davA_,
  input  logic [DATA_W-1:0] dataA,
  output logic              rfdA,
  input  logic              davB_,
  input  logic [DATA_W-1:0] dataB,
  output logic              rfdB,
  output logic              out,
  output logic              grant,
  output logic              busy,
  output logic [DATA_W-1:0] data_q,
  output logic [1:0]        dbg_state
);

  // Gap counter sized for GAP-1 down to 0; one bit minimum keeps GAP=0/1 legal.
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  state_t              r_state;
  logic                r_out;
  logic                r_rfd_a;
  logic                r_rfd_b;
  logic                r_grant;
  logic                r_busy;
  logic [DATA_W-1:0]   r_data_q;
  logic [LEN_W-1:0]    r_cnt;
  logic [GAP_W-1:0]    r_gap;

  state_t              w_state_nxt;
  logic                w_out_nxt;
  logic                w_rfd_a_nxt;
  logic                w_rfd_b_nxt;
  logic                w_grant_nxt;
  logic                w_busy_nxt;
  logic [DATA_W-1:0]   w_data_q_nxt;
  logic [LEN_W-1:0]    w_cnt_nxt;
  logic [GAP_W-1:0]    w_gap_nxt;

  logic                w_va;
  logic                w_vb;
  logic                w_valid;
  logic                w_win;
  logic [DATA_W-1:0]   w_win_data;
  logic                w_served_dav_;

  // A request counts only while its own rfd is already high.
  assign w_va = ~davA_ & r_rfd_a;
  assign w_vb = ~davB_ & r_rfd_b;

  impulse_rr_pick u_pick (
    .vA    (w_va),
    .vB    (w_vb),
    .last  (r_grant),
    .valid (w_valid),
    .win   (w_win)
  );

  assign w_win_data    = (w_win == CH_B) ? dataB : dataA;
  // In REL, r_grant names the channel being served.
  assign w_served_dav_ = (r_grant == CH_B) ? davB_ : davA_;

  // Next-state and next-output logic; every target defaults to hold.
  always_comb begin
    w_state_nxt  = r_state;
    w_out_nxt    = r_out;
    w_rfd_a_nxt  = r_rfd_a;
    w_rfd_b_nxt  = r_rfd_b;
    w_grant_nxt  = r_grant;
    w_busy_nxt   = r_busy;
    w_data_q_nxt = r_data_q;
    w_cnt_nxt    = r_cnt;
    w_gap_nxt    = r_gap;
    case (r_state)
      S_IDLE: begin
        w_rfd_a_nxt = 1'b1;
        w_rfd_b_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        if (w_valid) begin
          w_data_q_nxt = w_win_data;
          w_grant_nxt  = w_win;
          if (w_win == CH_A) begin
            w_rfd_a_nxt = 1'b0;
          end else begin
            w_rfd_b_nxt = 1'b0;
          end
          w_out_nxt   = 1'b1;
          w_cnt_nxt   = w_win_data[LEN_W-1:0];
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_PULSE;
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) begin
          w_out_nxt   = 1'b0;
          w_state_nxt = S_REL;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_REL: begin
        if (w_served_dav_) begin
          if (r_grant == CH_A) begin
            w_rfd_a_nxt = 1'b1;
          end else begin
            w_rfd_b_nxt = 1'b1;
          end
          if (GAP > 0) begin
            w_gap_nxt   = GAP_LOAD;
            w_state_nxt = S_GAP;
          end else begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gap == '0) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs and counters; reset truncates any pulse in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out    <= 1'b0;
      r_rfd_a  <= 1'b0;
      r_rfd_b  <= 1'b0;
      r_grant  <= CH_B;
      r_busy   <= 1'b0;
      r_data_q <= '0;
      r_cnt    <= '0;
      r_gap    <= '0;
    end else begin
      r_out    <= w_out_nxt;
      r_rfd_a  <= w_rfd_a_nxt;
      r_rfd_b  <= w_rfd_b_nxt;
      r_grant  <= w_grant_nxt;
      r_busy   <= w_busy_nxt;
      r_data_q <= w_data_q_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gap    <= w_gap_nxt;
    end
  end

  assign out       = r_out;
  assign rfdA      = r_rfd_a;
  assign rfdB      = r_rfd_b;
  assign grant     = r_grant;
  assign busy      = r_busy;
  assign data_q    = r_data_q;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_impulse_arbiter.sv
// Bench for impulse_arbiter: a GAP=2 and a GAP=0 instance share the same
// producer stimulus; each is compared every cycle against a timestamp-based
// reference model, plus directed checks and an accepted-byte scoreboard.
module tb_impulse_arbiter;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       davA_ = 1'b1;
  logic       davB_ = 1'b1;
  logic [7:0] dataA = 8'h00;
  logic [7:0] dataB = 8'h00;

  logic       rfdA, rfdB, out, grant, busy;
  logic [7:0] data_q;
  logic [1:0] dbg_state;
  logic       rfdA0, rfdB0, out0, grant0, busy0;
  logic [7:0] data_q0;
  logic [1:0] dbg_state0;

  impulse_arbiter #(.DATA_W(8), .LEN_W(4), .GAP(2)) dut (
    .clock(clock), .reset(reset),
    .davA_(davA_), .dataA(dataA), .rfdA(rfdA),
    .davB_(davB_), .dataB(dataB), .rfdB(rfdB),
    .out(out), .grant(grant), .busy(busy), .data_q(data_q),
    .dbg_state(dbg_state)
  );

  impulse_arbiter #(.DATA_W(8), .LEN_W(4), .GAP(0)) dut0 (
    .clock(clock), .reset(reset),
    .davA_(davA_), .dataA(dataA), .rfdA(rfdA0),
    .davB_(davB_), .dataB(dataB), .rfdB(rfdB0),
    .out(out0), .grant(grant0), .busy(busy0), .data_q(data_q0),
    .dbg_state(dbg_state0)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the served channel and the edge numbers at which its pulse
  // started and at which the line may be granted again.
  typedef struct {
    int         n;
    int         owner;
    int         t_acc;
    int         len;
    int         next_ok;
    int         acc;
    logic       last;
    logic [7:0] dq;
    logic [1:0] rfd;
    logic       out;
    logic       busy;
  } model_t;

  function automatic model_t model_next(input model_t m, input int gap, input logic rst,
                                        input logic da_, input logic [7:0] a,
                                        input logic db_, input logic [7:0] b);
    model_t     r;
    logic       va, vb;
    int         ch;
    logic [7:0] d;
    r     = m;
    r.n   = m.n + 1;
    r.acc = -1;
    if (rst) begin
      r.owner = -1; r.next_ok = 0; r.last = 1'b1; r.dq = 8'h00;
      r.rfd = 2'b00; r.out = 1'b0; r.busy = 1'b0;
      return r;
    end
    if (m.owner < 0) begin
      va    = !da_ && m.rfd[0];
      vb    = !db_ && m.rfd[1];
      r.rfd = 2'b11;
      if (r.n >= m.next_ok && (va || vb)) begin
        if (va && vb) ch = m.last ? 0 : 1;
        else          ch = vb ? 1 : 0;
        d         = (ch == 1) ? b : a;
        r.owner   = ch;
        r.t_acc   = r.n;
        r.len     = (int'(d) % 16) + 1;
        r.dq      = d;
        r.last    = (ch == 1);
        r.rfd[ch] = 1'b0;
        r.acc     = ch;
      end
    end else if (r.n > m.t_acc + m.len && ((m.owner == 1) ? db_ : da_)) begin
      r.rfd[m.owner] = 1'b1;
      r.next_ok      = r.n + gap + 1;
      r.owner        = -1;
    end
    r.out  = (r.owner >= 0) && (r.n < r.t_acc + r.len);
    r.busy = (r.owner >= 0) || (r.n < r.next_ok - 1);
    return r;
  endfunction

  model_t     m2, m0;
  logic [7:0] exp_q[$];
  bit         chk_en = 1'b0;
  logic       sb_prev = 1'b0;

  // Advance both models on the same edges the DUTs use.
  always @(posedge clock) begin
    m2 = model_next(m2, 2, reset, davA_, dataA, davB_, dataB);
    m0 = model_next(m0, 0, reset, davA_, dataA, davB_, dataB);
    if (m2.acc >= 0) exp_q.push_back(m2.dq);
  end

  // Per-cycle comparison of both instances and the accepted-byte scoreboard.
  always @(negedge clock) begin
    if (chk_en) begin
      check("g2_out",   32'(out),    32'(m2.out));
      check("g2_rfdA",  32'(rfdA),   32'(m2.rfd[0]));
      check("g2_rfdB",  32'(rfdB),   32'(m2.rfd[1]));
      check("g2_busy",  32'(busy),   32'(m2.busy));
      check("g2_grant", 32'(grant),  32'(m2.last));
      check("g2_dataq", 32'(data_q), 32'(m2.dq));
      check("g2_state_idle", 32'(dbg_state != 2'd0), 32'(m2.busy));
      check("g0_out",   32'(out0),    32'(m0.out));
      check("g0_rfdA",  32'(rfdA0),   32'(m0.rfd[0]));
      check("g0_rfdB",  32'(rfdB0),   32'(m0.rfd[1]));
      check("g0_busy",  32'(busy0),   32'(m0.busy));
      check("g0_grant", 32'(grant0),  32'(m0.last));
      check("g0_dataq", 32'(data_q0), 32'(m0.dq));
      if (out && !sb_prev) begin
        if (exp_q.size() == 0) check("sb_unexpected_pulse", 32'(exp_q.size()), 32'd1);
        else check("sb_byte", 32'(data_q), 32'(exp_q.pop_front()));
      end
    end
    sb_prev = out;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int ch, input logic dv, input logic [7:0] d);
    if (ch == 0) begin davA_ = dv; dataA = d; end
    else         begin davB_ = dv; dataB = d; end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Waits (bounded) for out to rise, then counts its high cycles.
  task automatic pulse_width(output int w);
    int guard;
    w = 0; guard = 0;
    while (!out && guard < 64) begin @(negedge clock); guard++; end
    if (!out) check("rise_timeout", 32'(out), 32'd1);
    else while (out && w < 64) begin w++; @(negedge clock); end
  endtask

  // Producers that hold each request until the model reports acceptance,
  // then keep dav_ low for the pulse plus a random tail.
  task automatic random_phase(input int cycles, input bit eager);
    int   hold[2];
    int   rest[2];
    bit   req[2];
    int   prev_g;
    logic prev_o;
    logic [7:0] d;
    for (int ch = 0; ch < 2; ch++) begin hold[ch] = -1; rest[ch] = 0; req[ch] = 1'b0; end
    prev_g = -1;
    prev_o = out;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      if (eager && out && !prev_o) begin
        if (prev_g >= 0) check("alternate", 32'(grant), 32'(prev_g == 0));
        prev_g = int'(grant);
      end
      prev_o = out;
      for (int ch = 0; ch < 2; ch++) begin
        if (!req[ch]) begin
          if (rest[ch] > 0) rest[ch]--;
          else if (eager || $urandom_range(0, 3) == 0) begin
            req[ch] = 1'b1; hold[ch] = -1;
            drive(ch, 1'b0, 8'($urandom));
          end
        end else if (hold[ch] < 0) begin
          d = (ch == 0) ? dataA : dataB;
          if (m2.acc == ch) hold[ch] = (int'(d) % 16) + 1 + $urandom_range(0, eager ? 2 : 8);
          else if (!eager && $urandom_range(0, 99) == 0) begin
            drive(ch, 1'b1, d); req[ch] = 1'b0; rest[ch] = 1;
          end
        end else if (hold[ch] == 0) begin
          d = (ch == 0) ? dataA : dataB;
          drive(ch, 1'b1, d); req[ch] = 1'b0;
          rest[ch] = eager ? 0 : $urandom_range(0, 4);
        end else begin
          hold[ch]--;
        end
      end
    end
    davA_ = 1'b1;
    davB_ = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w;
    int c2, c0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_en = 1'b1;
    check("rst_out",   32'(out),    32'd0);
    check("rst_rfdA",  32'(rfdA),   32'd0);
    check("rst_rfdB",  32'(rfdB),   32'd0);
    check("rst_busy",  32'(busy),   32'd0);
    check("rst_grant", 32'(grant),  32'd1);
    check("rst_dataq", 32'(data_q), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_rfdA", 32'(rfdA), 32'd1);
    check("post_rst_rfdB", 32'(rfdB), 32'd1);

    // Single A request, byte 0x05 -> 6-cycle pulse.
    drive(0, 1'b0, 8'h05);
    pulse_width(w);
    check("t1_width", 32'(w),      32'd6);
    check("t1_grant", 32'(grant),  32'd0);
    check("t1_dataq", 32'(data_q), 32'h05);
    check("t1_rfdA",  32'(rfdA),   32'd0);
    check("t1_rfdB",  32'(rfdB),   32'd1);
    davA_ = 1'b1;
    repeat (6) @(negedge clock);

    // Tie on the first arbitration after reset: A (1 cycle), then B (16).
    do_reset(1);
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h0F);
    pulse_width(w);
    check("t2_a_width", 32'(w),     32'd1);
    check("t2_a_grant", 32'(grant), 32'd0);
    check("t2_b_wait",  32'(rfdB),  32'd1);
    davA_ = 1'b1;
    pulse_width(w);
    check("t2_b_width", 32'(w),      32'd16);
    check("t2_b_grant", 32'(grant),  32'd1);
    check("t2_b_dataq", 32'(data_q), 32'h0F);
    davB_ = 1'b1;
    repeat (6) @(negedge clock);

    // Producer holds dav_ after its pulse; then release with B waiting.
    do_reset(1);
    drive(0, 1'b0, 8'h03);
    pulse_width(w);
    check("t5_width", 32'(w), 32'd4);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_out",  32'(out),  32'd0);
      check("t5_hold_rfdA", 32'(rfdA), 32'd0);
      check("t5_hold_busy", 32'(busy), 32'd1);
      @(negedge clock);
    end
    davA_ = 1'b1;
    drive(1, 1'b0, 8'h12);
    c2 = -1; c0 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i == 1) begin
        check("t5_rel_rfdA",  32'(rfdA),  32'd1);
        check("t5_rel_rfdA0", 32'(rfdA0), 32'd1);
      end
      if (out  && c2 < 0) c2 = i;
      if (out0 && c0 < 0) c0 = i;
    end
    check("t5_gap2_latency", 32'(c2), 32'd4);
    check("t5_gap0_latency", 32'(c0), 32'd2);
    davB_ = 1'b1;
    repeat (6) @(negedge clock);

    // Reset during the third cycle of a 10-cycle pulse.
    do_reset(1);
    drive(0, 1'b0, 8'h09);
    w = 0;
    while (!out && w < 20) begin @(negedge clock); w++; end
    check("t6_rise", 32'(out), 32'd1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t6_out",  32'(out),  32'd0);
    check("t6_rfdA", 32'(rfdA), 32'd0);
    check("t6_rfdB", 32'(rfdB), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    davA_ = 1'b1;
    @(negedge clock);
    check("t6_rfdA_up", 32'(rfdA), 32'd1);
    check("t6_rfdB_up", 32'(rfdB), 32'd1);

    // Both producers always requesting: grants must alternate.
    do_reset(1);
    random_phase(400, 1'b1);
    repeat (40) @(negedge clock);

    // Fully random traffic with withdrawals.
    random_phase(3000, 1'b0);
    repeat (60) @(negedge clock);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
